// File: rtl/knap_multi_seq.sv
// rtl/knap_multi_seq.sv - streaming knapsack selection checker with saturating totals
// Optional feature: define KNAP_EARLY_REJECT_EN to abort once weight or volume exceeds its limit.
module knap_multi_seq #(
    parameter int N_ITEMS = 11,
    parameter int W       = 8,
    parameter int ACC_W   = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [W-1:0]     min_value,
    input  logic [W-1:0]     max_weight,
    input  logic [W-1:0]     max_volume,
    input  logic             item_valid,
    output logic             item_ready,
    input  logic             item_sel,
    input  logic [W-1:0]     item_value,
    input  logic [W-1:0]     item_weight,
    input  logic [W-1:0]     item_volume,
    output logic             busy,
    output logic             done,
    output logic             valid,
    output logic [ACC_W-1:0] total_value,
    output logic [ACC_W-1:0] total_weight,
    output logic [ACC_W-1:0] total_volume,
    output logic             overflow,
    output logic             early_reject
);

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t           r_state, w_next_state;
    logic [7:0]       r_count;
    logic [W-1:0]     r_min, r_max_w, r_max_v;
    logic [ACC_W-1:0] r_tv, r_tw, r_to;
    logic             r_overflow, r_valid;
    logic [ACC_W:0]   w_sum_v, w_sum_w, w_sum_o;
    logic [ACC_W-1:0] w_tv, w_tw, w_to;
    logic             w_ovf, w_accept, w_last, w_exceed, w_pass, w_abort, w_finish;

    // One extra bit on each sum exposes the carry that triggers saturation.
    assign w_sum_v = {1'b0, r_tv} + (ACC_W+1)'(item_value);
    assign w_sum_w = {1'b0, r_tw} + (ACC_W+1)'(item_weight);
    assign w_sum_o = {1'b0, r_to} + (ACC_W+1)'(item_volume);

    assign w_tv  = !item_sel ? r_tv : (w_sum_v[ACC_W] ? '1 : w_sum_v[ACC_W-1:0]);
    assign w_tw  = !item_sel ? r_tw : (w_sum_w[ACC_W] ? '1 : w_sum_w[ACC_W-1:0]);
    assign w_to  = !item_sel ? r_to : (w_sum_o[ACC_W] ? '1 : w_sum_o[ACC_W-1:0]);
    assign w_ovf = item_sel && (w_sum_v[ACC_W] || w_sum_w[ACC_W] || w_sum_o[ACC_W]);

    assign w_accept = item_valid && (r_state == ACC);
    assign w_last   = (r_count == 8'(N_ITEMS - 1));
    assign w_exceed = (w_tw > ACC_W'(r_max_w)) || (w_to > ACC_W'(r_max_v));
    assign w_pass   = (w_tv >= ACC_W'(r_min)) && !w_exceed && !r_overflow && !w_ovf;
    assign w_finish = w_accept && (w_last || w_abort);

`ifdef KNAP_EARLY_REJECT_EN
    logic r_early;
    assign w_abort      = w_accept && w_exceed;
    assign early_reject = r_early;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_early <= 1'b0;
        end else if (r_state == IDLE && start) begin
            r_early <= 1'b0;
        end else if (w_finish) begin
            r_early <= w_abort;
        end
    end
`else
    assign w_abort      = 1'b0;
    assign early_reject = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start) w_next_state = ACC;
            ACC:     if (w_finish) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        item_ready = (r_state == ACC);
        busy       = (r_state != IDLE);
        done       = (r_state == DONE);
    end

    // Verdict is computed from the post-beat totals so it is ready alongside done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count    <= '0;
            r_min      <= '0;
            r_max_w    <= '0;
            r_max_v    <= '0;
            r_tv       <= '0;
            r_tw       <= '0;
            r_to       <= '0;
            r_overflow <= 1'b0;
            r_valid    <= 1'b0;
        end else if (r_state == IDLE && start) begin
            r_count    <= '0;
            r_min      <= min_value;
            r_max_w    <= max_weight;
            r_max_v    <= max_volume;
            r_tv       <= '0;
            r_tw       <= '0;
            r_to       <= '0;
            r_overflow <= 1'b0;
            r_valid    <= 1'b0;
        end else if (w_accept) begin
            r_count    <= w_last ? 8'd0 : r_count + 8'd1;
            r_tv       <= w_tv;
            r_tw       <= w_tw;
            r_to       <= w_to;
            r_overflow <= r_overflow || w_ovf;
            if (w_finish) r_valid <= w_pass && !w_abort;
        end
    end

    assign valid        = r_valid;
    assign overflow     = r_overflow;
    assign total_value  = r_tv;
    assign total_weight = r_tw;
    assign total_volume = r_to;

endmodule

// File: tb/tb_knap_multi_seq.sv
// tb/tb_knap_multi_seq.sv - directed and randomized checks against an arithmetic reference model
module tb_knap_multi_seq;
    localparam bit EARLY =
`ifdef KNAP_EARLY_REJECT_EN
        1'b1;
`else
        1'b0;
`endif

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, item_valid = 1'b0, item_sel = 1'b0;
    logic [7:0] min_value = '0, max_weight = '0, max_volume = '0;
    logic [7:0] item_value = '0, item_weight = '0, item_volume = '0;
    logic item_ready, busy, done, valid, overflow, early_reject;
    logic [11:0] total_value, total_weight, total_volume;
    logic item_ready_b, busy_b, done_b, valid_b, overflow_b, early_reject_b;
    logic [9:0] total_value_b, total_weight_b, total_volume_b;

    knap_multi_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .min_value(min_value), .max_weight(max_weight),
        .max_volume(max_volume), .item_valid(item_valid), .item_ready(item_ready), .item_sel(item_sel),
        .item_value(item_value), .item_weight(item_weight), .item_volume(item_volume), .busy(busy),
        .done(done), .valid(valid), .total_value(total_value), .total_weight(total_weight),
        .total_volume(total_volume), .overflow(overflow), .early_reject(early_reject));

    knap_multi_seq #(.ACC_W(10)) dut10 (
        .clk(clk), .rst_n(rst_n), .start(start), .min_value(min_value), .max_weight(max_weight),
        .max_volume(max_volume), .item_valid(item_valid), .item_ready(item_ready_b), .item_sel(item_sel),
        .item_value(item_value), .item_weight(item_weight), .item_volume(item_volume), .busy(busy_b),
        .done(done_b), .valid(valid_b), .total_value(total_value_b), .total_weight(total_weight_b),
        .total_volume(total_volume_b), .overflow(overflow_b), .early_reject(early_reject_b));

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    int bv[11], bw[11], bo[11];
    bit bs[11];
    int lmin, lmw, lmv;
    int n_acc, lat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: plain integer sums clamped at the accumulator ceiling.
    function automatic void model(input int accw, output int tv, output int tw, output int to,
                                  output bit ov, output bit vd, output bit er, output int n);
        int cap = (1 << accw) - 1;
        tv = 0; tw = 0; to = 0; ov = 0; er = 0; n = 0;
        for (int k = 0; k < 11; k++) begin
            n = k + 1;
            if (bs[k]) begin
                tv += bv[k]; tw += bw[k]; to += bo[k];
                if (tv > cap) begin tv = cap; ov = 1; end
                if (tw > cap) begin tw = cap; ov = 1; end
                if (to > cap) begin to = cap; ov = 1; end
            end
            if (EARLY && (tw > lmw || to > lmv)) begin er = 1; break; end
        end
        vd = !er && !ov && tv >= lmin && tw <= lmw && to <= lmv;
    endfunction

    task automatic run(input bit hold, input bit toggle, input int stop_after);
        int cyc = 0;
        bit acc;
        @(negedge clk);
        start = 1'b1;
        min_value = 8'(lmin); max_weight = 8'(lmw); max_volume = 8'(lmv);
        @(negedge clk);
        start = hold;
        if (hold) begin
            min_value = 8'($urandom); max_weight = 8'($urandom); max_volume = 8'($urandom);
        end
        n_acc = 0; lat = 0;
        while (done !== 1'b1 && cyc < 300 && n_acc != stop_after) begin
            if (n_acc < 11) begin
                item_valid  = toggle ? (cyc % 2 == 0) : 1'b1;
                item_sel    = bs[n_acc];
                item_value  = 8'(bv[n_acc]);
                item_weight = 8'(bw[n_acc]);
                item_volume = 8'(bo[n_acc]);
            end else item_valid = 1'b0;
            acc = item_valid && item_ready;
            @(negedge clk);
            cyc++;
            if (acc) begin n_acc++; lat = 0; end else lat++;
        end
        item_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic check_result(input string tag, input bit use10);
        int tv, tw, to, n;
        bit ov, vd, er;
        model(12, tv, tw, to, ov, vd, er, n);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_latency"}, lat, 0);
        chk({tag, "_beats"}, n_acc, n);
        chk({tag, "_tv"}, total_value, tv);
        chk({tag, "_tw"}, total_weight, tw);
        chk({tag, "_to"}, total_volume, to);
        chk({tag, "_ovf"}, overflow, ov);
        chk({tag, "_valid"}, valid, vd);
        chk({tag, "_early"}, early_reject, er);
        chk({tag, "_ready"}, item_ready, 0);
        if (use10) begin
            model(10, tv, tw, to, ov, vd, er, n);
            chk({tag, "_b_tv"}, total_value_b, tv);
            chk({tag, "_b_tw"}, total_weight_b, tw);
            chk({tag, "_b_to"}, total_volume_b, to);
            chk({tag, "_b_ovf"}, overflow_b, ov);
            chk({tag, "_b_valid"}, valid_b, vd);
        end
        model(12, tv, tw, to, ov, vd, er, n);
        @(negedge clk);
        chk({tag, "_done_drop"}, {busy, done}, 0);
        chk({tag, "_valid_hold"}, valid, vd);
        chk({tag, "_tv_hold"}, total_value, tv);
    endtask

    task automatic load_directed();
        bv = '{4, 8, 0, 20, 10, 12, 18, 14, 6, 15, 30};
        bw = '{28, 8, 27, 18, 27, 28, 6, 1, 20, 0, 5};
        bo = '{27, 27, 4, 4, 0, 24, 4, 20, 12, 15, 5};
        bs = '{0, 0, 0, 1, 1, 0, 1, 1, 0, 1, 1};
        lmin = 107; lmw = 60; lmv = 60;
    endtask

    task automatic load_random();
        for (int k = 0; k < 11; k++) begin
            bv[k] = $urandom_range(0, 40); bw[k] = $urandom_range(0, 30);
            bo[k] = $urandom_range(0, 30); bs[k] = 1'($urandom);
        end
        lmin = $urandom_range(0, 150); lmw = $urandom_range(30, 200); lmv = $urandom_range(30, 200);
    endtask

    initial begin
        #12;
        @(negedge clk);
        chk("reset_ctrl", {busy, done, item_ready, valid, overflow, early_reject}, 0);
        chk("reset_totals", {total_value, total_weight, total_volume}, 0);
        rst_n = 1'b1;

        load_directed();
        run(0, 0, -1);
        check_result("basic", 0);
        chk("basic_tv_const", total_value, 107);

        load_directed();
        bs[5] = 1'b1;
        run(0, 0, -1);
        check_result("sel6", 0);

        for (int k = 0; k < 11; k++) begin bv[k] = 255; bw[k] = 255; bo[k] = 255; bs[k] = 1; end
        lmin = 0; lmw = 255; lmv = 255;
        run(0, 0, -1);
        check_result("sat", 1);

        load_random();
        run(0, 1, -1);
        check_result("toggle", 0);

        load_random();
        run(0, 0, 5);
        chk("mid_beats", n_acc, 5);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ctrl", {busy, done, item_ready, valid, overflow, early_reject}, 0);
        chk("mid_rst_totals", {total_value, total_weight, total_volume}, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("mid_rst_nodone", {done, busy}, 0);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_rst_idle", {done, busy, item_ready}, 0);
        end
        load_random();
        run(0, 0, -1);
        check_result("after_rst", 0);

        load_directed();
        run(1, 0, -1);
        check_result("hold_start", 0);

        for (int r = 0; r < 16; r++) begin
            load_random();
            run(0, r % 2 == 1, -1);
            check_result($sformatf("rand%0d", r), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/knap_multi_seq.md
KNAP_MULTI_SEQ -- requirements
Module: knap_multi_seq

Interface
REQ-001 SHALL have parameter N_ITEMS, default 11; number of items per evaluation, range 1..255.
REQ-002 SHALL have parameter W, default 8; width of per-item value, weight and volume, and of each threshold.
REQ-003 SHALL have parameter ACC_W, default 12; width of each running total, ACC_W >= W.
REQ-004 SHALL have port clk, input, 1 bit; single clock, all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit; reset, asynchronous, active-low.
REQ-006 SHALL have port start, input, 1 bit; begins an evaluation.
REQ-007 SHALL have ports min_value, max_weight and max_volume, input, W bits each; thresholds, sampled on an accepted start.
REQ-008 SHALL have port item_valid, input, 1 bit; the item beat is present.
REQ-009 SHALL have port item_ready, output, 1 bit; the block accepts an item beat.
REQ-010 SHALL have port item_sel, input, 1 bit; the item is selected.
REQ-011 SHALL have ports item_value, item_weight and item_volume, input, W bits each; item attributes.
REQ-012 SHALL have port busy, output, 1 bit; an evaluation is in progress.
REQ-013 SHALL have port done, output, 1 bit; one-cycle completion pulse.
REQ-014 SHALL have port valid, output, 1 bit; the selection meets all constraints.
REQ-015 SHALL have ports total_value, total_weight and total_volume, output, ACC_W bits each; running or final totals.
REQ-016 SHALL have port overflow, output, 1 bit; sticky flag, some total saturated.
REQ-017 SHALL have port early_reject, output, 1 bit; the evaluation was aborted early (see REQ-032).

Function
REQ-018 SHALL implement an FSM with states IDLE, ACC and DONE.
REQ-019 SHALL, in IDLE with start=1, clear all totals, overflow, valid, early_reject and the item count, latch the thresholds, and enter ACC.
REQ-020 SHALL ignore start in ACC and DONE.
REQ-021 SHALL drive item_ready=1 only in ACC; an item beat is accepted when item_valid and item_ready are both 1.
REQ-022 SHALL, on an accepted item with item_sel=1, add each zero-extended attribute to its total; an item with item_sel=0 only advances the count.
REQ-023 SHALL saturate each total at 2^ACC_W-1 and set overflow on saturation; overflow stays set until the next accepted start.
REQ-024 SHALL enter DONE on the cycle after item number N_ITEMS is accepted (count wraps to 0).
REQ-025 SHALL assert done for exactly one cycle in DONE, then return to IDLE.
REQ-026 SHALL register valid in DONE as: total_value >= min_value AND total_weight <= max_weight AND total_volume <= max_volume AND NOT overflow.
- Comparisons are unsigned, with the thresholds zero-extended to ACC_W.
- valid holds its value until the next accepted start.
REQ-027 SHALL assert busy in ACC and DONE.
REQ-028 SHALL keep the totals readable after done until the next accepted start.
REQ-029 SHALL, when N_ITEMS=1, enter DONE on the cycle after the single beat is accepted.

Reset
REQ-030 SHALL, while rst_n=0, set state=IDLE, clear the item count, and drive every output to 0, including item_ready.
REQ-031 SHALL, on reset during ACC or DONE, discard the evaluation with no done pulse; a new start is needed after release.

Configuration
REQ-032 SHALL, with KNAP_EARLY_REJECT_EN defined, abort an evaluation in ACC when total_weight > max_weight or total_volume > max_volume after an accepted beat.
- The block enters DONE on the next cycle with valid=0 and early_reject=1.
- Remaining beats are not consumed.
REQ-033 SHALL, without KNAP_EARLY_REJECT_EN, always consume all N_ITEMS beats and tie early_reject to 0.

Verification
REQ-034 SHALL cover: defaults, thresholds 107/60/60.
- Stimulus: 11 beats, value/weight/volume = (4,28,27)(8,8,27)(0,27,4)(20,18,4)(10,27,0)(12,28,24)(18,6,4)(14,1,20)(6,20,12)(15,0,15)(30,5,5), sel=0,0,0,1,1,0,1,1,0,1,1.
- Response: done one cycle after the last beat; totals 107/57/48; valid=1.
REQ-035 SHALL cover: same beats with sel of beat 6 set to 1.
- Without the macro: totals 119/85/72, valid=0.
- With the macro: abort after beat 6 (weight 73), done one cycle later, early_reject=1, valid=0, item_ready=0 thereafter.
REQ-036 SHALL cover: ACC_W=10, 11 beats of all 255, sel=1 -> totals 1023, overflow=1, valid=0.
REQ-037 SHALL cover: item_valid toggled 1/0 each cycle -> only the handshaked beats are counted; done after the 11th accepted beat.
REQ-038 SHALL cover: rst_n low after 5 beats -> all outputs 0, no done pulse; a new start evaluates 11 fresh beats correctly.
REQ-039 SHALL cover: start held high through ACC -> ignored; thresholds stay at their latched values.
